// File: rtl/tt_bist_harness.sv
// tt_bist_harness: on-chip stimulus/response harness for tt_um_* user cores.
// An LFSR drives a pseudo-random word stream into the user core. A MISR
// compresses the returned responses, after compensating for the core's
// latency, into a signature. That signature is compared with a golden value.
// Optional feature macro: TT_BIST_HARNESS_ABORT_EN adds the abort input and
// the aborted status output.

module tt_bist_harness #(
  parameter int                DATA_W    = 8,
  parameter int                RESP_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8,
  parameter logic [RESP_W-1:0] MISR_POLY = 8'hB8,
  parameter logic [DATA_W-1:0] SEED      = 8'h01,
  parameter int                CYCLES    = 256,
  parameter int                LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RESP_W-1:0] expected,
  output logic [DATA_W-1:0] stim_out,
  output logic              stim_valid,
  input  logic [RESP_W-1:0] resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature
`ifdef TT_BIST_HARNESS_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;

  // The counter is wide enough to hold CYCLES, so it never wraps inside a run.
  localparam int              CNT_W      = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CYCLES - 1);

  localparam int              DRN_W      = 4;
  localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] lfsr_q;
  logic              stimValid_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [RESP_W-1:0] sig_q;
  logic [RESP_W-1:0] sig_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DRN_W-1:0]  drainCnt_q;
  logic [LAT-1:0]    capPipe_q;
  logic [LAT-1:0]    capPipe_d;
  logic [DATA_W-1:0] lfsrNext;
  logic              capEn;
  logic              abortReq;

`ifdef TT_BIST_HARNESS_ABORT_EN
  logic              aborted_q;
  assign abortReq = abort && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign abortReq = 1'b0;
`endif

  // Galois right-shift LFSR step that produces the next stimulus word.
  always_comb begin
    lfsrNext = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
  end

  // The valid delay line matches the core latency, so each capture lines up
  // with the response to a word that was part of the run.
  always_comb begin
    capPipe_d    = '0;
    capPipe_d[0] = stimValid_q;
    for (int i = 1; i < LAT; i++) begin
      capPipe_d[i] = capPipe_q[i-1];
    end
  end

  assign capEn = capPipe_q[LAT-1];

  // The MISR folds the current response into the signature on every capture.
  always_comb begin
    sig_d = sig_q;
    if (capEn) begin
      sig_d = (sig_q >> 1) ^ (sig_q[0] ? MISR_POLY : '0) ^ resp_in;
    end
  end

  // Main controller: run sequencing, stimulus generation, signature and verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      stimValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      sig_q       <= '0;
      cnt_q       <= '0;
      drainCnt_q  <= '0;
      capPipe_q   <= '0;
    end else if (abortReq) begin
      state_q     <= DONE;
      stimValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b1;
      pass_q      <= 1'b0;
      capPipe_q   <= '0;
    end else begin
      capPipe_q <= capPipe_d;
      sig_q     <= sig_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= RUN;
            lfsr_q      <= SEED_EFF;
            sig_q       <= '0;
            cnt_q       <= '0;
            drainCnt_q  <= '0;
            capPipe_q   <= '0;
            stimValid_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q     <= DRAIN;
            stimValid_q <= 1'b0;
            drainCnt_q  <= '0;
          end else begin
            lfsr_q <= lfsrNext;
          end
        end
        DRAIN: begin
          if (drainCnt_q == LAST_DRN) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_d == expected);
          end else begin
            drainCnt_q <= drainCnt_q + DRN_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef TT_BIST_HARNESS_ABORT_EN
  // Sticky abort flag. It is set by an honoured abort and cleared by a new run or by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else if (abortReq) begin
      aborted_q <= 1'b1;
    end else if (start && ((state_q == IDLE) || (state_q == DONE))) begin
      aborted_q <= 1'b0;
    end
  end

  assign aborted = aborted_q;
`endif

  assign stim_out   = lfsr_q;
  assign stim_valid = stimValid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;

endmodule

// File: doc/tt_bist_harness.md
Name: tt_bist_harness

Overview:
- Synthesizable, parametrised stimulus/response harness for tt_um_* user designs; the on-chip successor to our plain simulation wrapper.
- Generates a pseudo-random stimulus stream with an LFSR and drives it onto a DUT input bus.
- Compresses the DUT response stream, latency-compensated, into a MISR signature and compares it against an expected value.
- Sits between the tt_um top-level pins and the user core: self-test without a cocotb bench.

Parameters:
- DATA_W, 8, stimulus width (≥2).
- RESP_W, 8, response/signature width (≥2).
- LFSR_POLY, 8'hB8, Galois taps for stimulus LFSR (DATA_W bits).
- MISR_POLY, 8'hB8, Galois taps for MISR (RESP_W bits).
- SEED, 8'h01, LFSR start value; all-zero is replaced by 1.
- CYCLES, 256, stimulus words per run (1..65535).
- LAT, 1, DUT latency in clocks from stim_out to matching resp_in (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle run request, honoured only in IDLE or DONE.
- expected  in  RESP_W  golden signature, sampled on entry to DONE.
- stim_out  out  DATA_W  stimulus word to DUT.
- stim_valid  out  1  stim_out is part of the run.
- resp_in  in  RESP_W  DUT response.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level, high in DONE.
- pass  out  1  signature==expected, valid while done.
- signature  out  RESP_W  current MISR contents.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Clock and reset ports are named clk and rst.
- Reset values: state IDLE, stim_out=SEED (or 1 if SEED==0), stim_valid=0, busy=0, done=0, pass=0, signature=0, cycle counter=0, valid delay line=0.
- FSM states and transitions:
  - IDLE --start--> RUN.
  - RUN: stim_valid=1 for exactly CYCLES consecutive clocks.
  - RUN --last word--> DRAIN.
  - DRAIN: LAT clocks.
  - DRAIN --> DONE.
  - DONE --start--> RUN.
- Run restart: on the start edge, stim_out reloads SEED, signature clears to 0, counter clears. The first RUN cycle presents the SEED word.
- LFSR: Galois right-shift. next = (s>>1) ^ (s[0] ? LFSR_POLY : 0). Advances once per RUN cycle after the word is presented.
- stim_out holds its last value outside RUN.
- Capture: stim_valid is delayed through a LAT-deep register chain to form cap_en.
- MISR, when cap_en=1: sig <= (sig>>1) ^ (sig[0] ? MISR_POLY : 0) ^ resp_in. Exactly CYCLES captures per run.
- DRAIN length LAT guarantees the last capture lands before DONE.
- DONE: done=1. pass registered once on entry as (signature==expected). signature frozen.
- start ignored while busy.
- rst in any state returns to reset values on the next edge; a partial signature is discarded.
- start and rst in the same cycle: rst wins.
- CYCLES=1: a single RUN cycle, then DRAIN.
- Counter width is clog2(CYCLES+1); no wrap inside a run.

Optional Feature:
- Macro: TT_BIST_HARNESS_ABORT_EN.
- With the macro: adds input port abort (1 bit).
  - abort=1 in RUN or DRAIN forces DONE next cycle with pass=0.
  - Adds output aborted=1 until the next start or rst.
  - abort in IDLE/DONE has no effect.
- Without the macro: neither port exists. A run always completes CYCLES+LAT busy cycles.

Test Plan:
- Reset value check: rst=1 for 2 clocks, defaults -> stim_out=8'h01, stim_valid=0, busy=0, done=0, signature=8'h00.
- LFSR sequence: start pulse, CYCLES=6 -> stim_out = 01,B8,5C,2E,17,B3 on successive RUN cycles. busy high 7 cycles (LAT=1). done rises on the following cycle.
- Zero response: resp_in=0, CYCLES=4, expected=8'h00 -> signature=8'h00, pass=1.
- Constant response: resp_in=8'hFF, CYCLES=2, LAT=1.
  - expected=8'h38 -> signature=8'h38, pass=1.
  - expected=8'h37 -> pass=0.
- Loopback through a 3-flop DUT, LAT=3, CYCLES=256: run twice back-to-back via start in DONE -> identical signatures, pass=1 with the captured golden. start pulses during busy are ignored.
- Mid-run rst at RUN cycle 10 -> next cycle IDLE, signature=0, stim_out=01. With TT_BIST_HARNESS_ABORT_EN, abort at cycle 10 -> done=1, pass=0, aborted=1.
